// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer write path.
package fb_pkg;
  localparam int PIX_WIDTH  = 16;
  localparam int WORD_WIDTH = 2 * PIX_WIDTH;
  localparam int FB_DEPTH   = 19200;

  typedef logic [PIX_WIDTH-1:0]  pixel_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {IDLE, HALF, EVEN} fb_wr_state_e;

  localparam logic [3:0] WE_FULL = 4'b1111;
  localparam logic [3:0] WE_LOW  = 4'b0011;

  typedef struct packed {
    pixel_t data;
    logic   sof;
    logic   eof;
  } pix_beat_t;

  // One cycle's worth of packer decisions, consumed by the address/flag stage.
  typedef struct packed {
    logic       write;
    logic [3:0] we;
    word_t      word;
    logic       last;
    logic       sof;
    logic       err;
  } wr_act_t;

  function automatic word_t pack_low(input pixel_t p);
    return {{PIX_WIDTH{1'b0}}, p};
  endfunction
endpackage

// File: rtl/fb_pixel_writer_if.sv
// Pixel stream handshake between a source and the frame-buffer writer.
interface fb_pix_if;
  import fb_pkg::*;
  pixel_t data;
  logic   valid;
  logic   sof;
  logic   eof;
  logic   ready;

  modport master (output data, valid, sof, eof, input ready);
  modport slave  (input data, valid, sof, eof, output ready);
endinterface

// File: rtl/fb_pixel_packer.sv
// Pairs incoming pixels into words; decisions are combinational so the
// top can register them alongside the address in the same cycle.
module fb_pixel_packer
  import fb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      accept,
  input  pix_beat_t beat,
  output wr_act_t   act
);
  fb_wr_state_e state;
  pixel_t       held;

  always_comb begin
    act = '0;
    if (accept) begin
      if (beat.sof) begin
        act.sof = 1'b1;
        act.err = (state != IDLE);
        if (beat.eof) begin
          act.write = 1'b1;
          act.we    = WE_LOW;
          act.word  = pack_low(beat.data);
          act.last  = 1'b1;
        end
      end else begin
        case (state)
          HALF: begin
            act.write = 1'b1;
            act.we    = WE_FULL;
            act.word  = {beat.data, held};
            act.last  = beat.eof;
          end
          EVEN: begin
            if (beat.eof) begin
              act.write = 1'b1;
              act.we    = WE_LOW;
              act.word  = pack_low(beat.data);
              act.last  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A SOF always restarts with its pixel as the lower half, dropping any held one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      held  <= '0;
    end else if (accept) begin
      if (beat.sof || state == EVEN) begin
        held  <= beat.data;
        state <= beat.eof ? IDLE : HALF;
      end else if (state == HALF) begin
        state <= beat.eof ? IDLE : EVEN;
      end
    end
  end
endmodule

// File: rtl/fb_pixel_writer.sv
// Packs a 16-bit pixel stream two-per-word into the frame BRAM write port.
module fb_pixel_writer #(
  parameter int                    RAM_DEPTH  = 19200,
  parameter int                    PIX_WIDTH  = 16,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  fb_pix_if.slave                s_pix,
  output logic [ADDR_WIDTH-1:0]  bram_addra,
  output logic [2*PIX_WIDTH-1:0] bram_dina,
  output logic [3:0]             bram_wea,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   overflow,
  output logic [14:0]            words_written
);
  import fb_pkg::*;

  localparam int            IW       = $clog2(RAM_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(RAM_DEPTH - 1);

  logic          accept;
  pix_beat_t     beat;
  wr_act_t       act;
  logic [IW-1:0] word_idx;
  logic [IW-1:0] cur_idx;

  assign s_pix.ready = enable & ~reset;
  assign accept      = s_pix.valid & s_pix.ready;
  assign beat        = '{data: s_pix.data, sof: s_pix.sof, eof: s_pix.eof};

  fb_pixel_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
    .beat   (beat),
    .act    (act)
  );

  // A one-pixel frame writes on its SOF beat, so the restart must take effect immediately.
  assign cur_idx = act.sof ? '0 : word_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      bram_addra    <= '0;
      bram_dina     <= '0;
      bram_wea      <= '0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
      words_written <= '0;
      word_idx      <= '0;
    end else begin
      bram_wea   <= '0;
      frame_done <= 1'b0;
      frame_err  <= act.err;
      if (act.sof) begin
        word_idx <= '0;
        overflow <= 1'b0;
      end
      if (act.write) begin
        bram_wea   <= act.we;
        bram_dina  <= act.word;
        bram_addra <= BASE_ADDR + ADDR_WIDTH'({cur_idx, 2'b00});
        if (act.last) begin
          frame_done    <= 1'b1;
          words_written <= 15'({1'b0, cur_idx} + 1'b1);
        end else if (cur_idx == LAST_IDX) begin
          // Keep writing over the top of the frame; the host sees the sticky flag.
          word_idx <= '0;
          overflow <= 1'b1;
        end else begin
          word_idx <= cur_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: expected writes queued at stimulus, popped by a monitor.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  fb_pix_if pix ();

  logic [31:0] bram_addra;
  logic [31:0] bram_dina;
  logic [3:0]  bram_wea;
  logic        frame_done;
  logic        frame_err;
  logic        overflow;
  logic [14:0] words_written;

  fb_pixel_writer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .s_pix         (pix),
    .bram_addra    (bram_addra),
    .bram_dina     (bram_dina),
    .bram_wea      (bram_wea),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .overflow      (overflow),
    .words_written (words_written)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] we, input logic done);
    exp_q.push_back('{addr: a, din: d, we: we, done: done});
  endtask

  function automatic logic [31:0] w2(input int lo, input int hi);
    return {hi[15:0], lo[15:0]};
  endfunction

  task automatic send(input logic [15:0] d, input logic sof, input logic eof);
    int n;
    n = 0;
    pix.data  = d;
    pix.sof   = sof;
    pix.eof   = eof;
    pix.valid = 1'b1;
    @(posedge clk);
    while (!pix.ready && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (!pix.ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ready stayed %b for pixel %h, required 1", pix.ready, d);
    end
    #1;
  endtask

  task automatic idle();
    pix.valid = 1'b0;
    pix.sof   = 1'b0;
    pix.eof   = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every cycle with a write must match the head of the queue.
  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (bram_wea != 4'b0000) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got addr=%0d din=%h we=%b, required no write",
                 bram_addra, bram_dina, bram_wea);
      end else begin
        mon_e = exp_q.pop_front();
        if (bram_addra !== mon_e.addr || bram_dina !== mon_e.din ||
            bram_wea !== mon_e.we || frame_done !== mon_e.done) begin
          fails++;
          $display("FAIL write: got addr=%0d din=%h we=%b done=%b, required addr=%0d din=%h we=%b done=%b",
                   bram_addra, bram_dina, bram_wea, frame_done,
                   mon_e.addr, mon_e.din, mon_e.we, mon_e.done);
        end
      end
    end else if (frame_done) begin
      tests++;
      fails++;
      $display("FAIL done_without_write: got frame_done=1 wea=0, required frame_done with a write");
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pix.data = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", pix.ready, 0);
    chk("rst_wea", bram_wea, 0);
    chk("rst_addr", bram_addra, 0);
    chk("rst_din", bram_dina, 0);
    chk("rst_flags", {frame_done, frame_err, overflow}, 0);
    chk("rst_ww", words_written, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    enable = 1'b1;

    // Non-SOF beat in IDLE is dropped.
    send(16'hDEAD, 1'b0, 1'b0);
    idle();
    drain();

    // Full frame with a 3-cycle enable drop mid-frame.
    for (int i = 0; i < 19200; i++)
      expect_wr(32'(4 * i), w2(2 * i, 2 * i + 1), WE_FULL, i == 19199);
    for (int i = 0; i < 38400; i++) begin
      if (i == 1001) begin
        pix.data  = 16'(i);
        pix.sof   = 1'b0;
        pix.eof   = 1'b0;
        pix.valid = 1'b1;
        enable    = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_ready", pix.ready, 0);
          chk("bp_no_write", bram_wea, 0);
        end
        @(posedge clk);
        #1 enable = 1'b1;
      end
      send(16'(i), i == 0, i == 38399);
    end
    idle();
    drain();
    chk("full_ww", words_written, 19200);
    chk("full_ovf", overflow, 0);

    // Odd frame.
    expect_wr(0, w2(16'hA, 16'hB), WE_FULL, 1'b0);
    expect_wr(4, 32'h0000_000C, WE_LOW, 1'b1);
    send(16'hA, 1'b1, 1'b0);
    send(16'hB, 1'b0, 1'b0);
    send(16'hC, 1'b0, 1'b1);
    idle();
    drain();
    chk("odd_ww", words_written, 2);

    // SOF mid-frame: pixel 5 held and dropped.
    expect_wr(0, w2(1, 2), WE_FULL, 1'b0);
    expect_wr(4, w2(3, 4), WE_FULL, 1'b0);
    expect_wr(0, w2(16'h55, 16'h66), WE_FULL, 1'b1);
    for (int i = 1; i <= 5; i++) send(16'(i), i == 1, 1'b0);
    send(16'h55, 1'b1, 1'b0);
    send(16'h66, 1'b0, 1'b1);
    idle();
    drain();
    chk("sofmid_ww", words_written, 1);
    chk("sofmid_err_count", err_seen, 1);

    // One-pixel frame.
    expect_wr(0, 32'h0000_0077, WE_LOW, 1'b1);
    send(16'h77, 1'b1, 1'b1);
    idle();
    drain();
    chk("onepix_ww", words_written, 1);

    // Overflow: 38402 pixels, word 0 rewritten.
    for (int i = 0; i < 19200; i++)
      expect_wr(32'(4 * i), w2(2 * i, 2 * i + 1), WE_FULL, 1'b0);
    expect_wr(0, w2(38400, 38401), WE_FULL, 1'b1);
    for (int i = 0; i < 38402; i++) send(16'(i), i == 0, i == 38401);
    idle();
    drain();
    chk("ovf_flag", overflow, 1);
    chk("ovf_ww", words_written, 1);

    // Next SOF clears overflow; then reset mid-frame after 7 pixels.
    expect_wr(0, w2(16'h100, 16'h101), WE_FULL, 1'b0);
    expect_wr(4, w2(16'h102, 16'h103), WE_FULL, 1'b0);
    expect_wr(8, w2(16'h104, 16'h105), WE_FULL, 1'b0);
    send(16'h100, 1'b1, 1'b0);
    @(negedge clk);
    chk("sof_clears_ovf", overflow, 0);
    for (int i = 1; i < 7; i++) send(16'(16'h100 + i), 1'b0, 1'b0);
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_mid_ready", pix.ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_wea", bram_wea, 0);
    chk("rst_mid_addr", bram_addra, 0);
    chk("rst_mid_din", bram_dina, 0);
    chk("rst_mid_ww", words_written, 0);
    chk("rst_mid_flags", {frame_done, frame_err, overflow}, 0);

    expect_wr(0, w2(16'h200, 16'h201), WE_FULL, 1'b1);
    send(16'h200, 1'b1, 1'b0);
    send(16'h201, 1'b0, 1'b1);
    idle();
    drain();
    chk("post_rst_ww", words_written, 1);

    chk("queue_empty", exp_q.size(), 0);
    chk("err_total", err_seen, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
